// File: rtl/cla8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cla8_seq_ctrl
//   Multi-cycle sequencer that performs a WIDTH-bit add on a single shared
//   8-bit CLA slice. Operands are latched on an accepted start. The slice is
//   fed one byte per cycle, LSB first, and the carry is chained between bytes.
//   The full sum and carry-out are published together with a one-cycle done
//   pulse.
//
//   Optional feature macro: CLA8_SEQ_SUB_EN
//     When defined, adds input i_sub. When i_sub=1 the block computes a-b
//     (b is inverted, carry-in forced to 1, i_cin ignored). In that mode
//     o_cout=1 means no borrow.
//
// Parameters
//   WIDTH  operand width, a multiple of 8 and >= 8
//   CNT_W  byte-index counter width, 2**CNT_W >= WIDTH/8
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active low
//   i_start    in   1      request, sampled only in IDLE
//   i_a, i_b   in   WIDTH  operands, captured when start is accepted
//   i_cin      in   1      carry-in, captured when start is accepted
//   i_sub      in   1      subtract select (only with CLA8_SEQ_SUB_EN)
//   o_busy     out  1      high in RUN
//   o_done     out  1      one-cycle pulse, result valid from this cycle on
//   o_sum      out  WIDTH  result, holds until the next done
//   o_cout     out  1      carry out of bit WIDTH-1
//   o_cla_a    out  8      operand A byte to the slice (0 outside RUN)
//   o_cla_b    out  8      operand B byte to the slice (0 outside RUN)
//   o_cla_cin  out  1      chained carry to the slice (0 outside RUN)
//   i_cla_s    in   8      slice sum, same cycle
// -----------------------------------------------------------------------------
module cla8_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef CLA8_SEQ_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic [7:0]       o_cla_a,
    output logic [7:0]       o_cla_b,
    output logic             o_cla_cin,
    input  logic [7:0]       i_cla_s
);

    localparam int NBYTES = WIDTH / 8;
    localparam int NSLOT  = 2 ** CNT_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CNT_W-1:0] r_idx;

    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_b_in;
    logic             w_cin_in;
    logic             w_last;
    logic             w_byte_carry;

    // Byte views of the latched operands. The tables are padded to the full
    // counter range so indexing by r_idx never goes out of bounds.
    logic [7:0]       w_a_byte [NSLOT];
    logic [7:0]       w_b_byte [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NBYTES) begin : g_used
                assign w_a_byte[gi] = r_a[8*gi +: 8];
                assign w_b_byte[gi] = r_b[8*gi +: 8];
                // Merge the current slice result into the accumulator image
                // so the final byte can be published in the same edge.
                assign w_acc_next[8*gi +: 8] =
                    (r_idx == CNT_W'(gi)) ? i_cla_s : r_acc[8*gi +: 8];
            end else begin : g_pad
                assign w_a_byte[gi] = 8'd0;
                assign w_b_byte[gi] = 8'd0;
            end
        end
    endgenerate

`ifdef CLA8_SEQ_SUB_EN
    // a - b = a + ~b + 1
    assign w_b_in   = i_sub ? ~i_b : i_b;
    assign w_cin_in = i_sub ? 1'b1 : i_cin;
`else
    assign w_b_in   = i_b;
    assign w_cin_in = i_cin;
`endif

    assign w_last = (r_idx == CNT_W'(NBYTES - 1));

    // Carry out of the byte rebuilt from the top bit alone: when a7^b7 the
    // incoming bit-7 carry equals ~s7 and propagates; otherwise it is g7.
    assign w_byte_carry = (o_cla_a[7] & o_cla_b[7])
                        | ((o_cla_a[7] ^ o_cla_b[7]) & ~i_cla_s[7]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_cla_a      = 8'd0;
        o_cla_b      = 8'd0;
        o_cla_cin    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                o_busy    = 1'b1;
                o_cla_a   = w_a_byte[r_idx];
                o_cla_b   = w_b_byte[r_idx];
                o_cla_cin = r_carry;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= w_b_in;
                        r_carry <= w_cin_in;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_byte_carry;
                    r_idx   <= r_idx + CNT_W'(1);
                    // Result registers only move once all bytes are in.
                    if (w_last) begin
                        o_sum  <= w_acc_next;
                        o_cout <= w_byte_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla8_seq_ctrl.sv
module tb_cla8_seq_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    // WIDTH=32 instance
    logic        start = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        cin   = 1'b0;
    logic        sub   = 1'b0;
    logic        busy, done, cout, cla_cin;
    logic [31:0] sum;
    logic [7:0]  cla_a, cla_b, cla_s;

    // WIDTH=8 instance
    logic        start8 = 1'b0;
    logic [7:0]  a8     = '0;
    logic [7:0]  b8     = '0;
    logic        cin8   = 1'b0;
    logic        busy8, done8, cout8, cla_cin8;
    logic [7:0]  sum8;
    logic [7:0]  cla_a8, cla_b8, cla_s8;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_sum = '0;
    logic        cin_seen [4];

    // Behavioural 8-bit adder slice
    assign cla_s  = cla_a  + cla_b  + {7'd0, cla_cin};
    assign cla_s8 = cla_a8 + cla_b8 + {7'd0, cla_cin8};

    always #5 clk = ~clk;

    cla8_seq_ctrl #(.WIDTH(32), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (start),
        .i_a       (a),
        .i_b       (b),
        .i_cin     (cin),
`ifdef CLA8_SEQ_SUB_EN
        .i_sub     (sub),
`endif
        .o_busy    (busy),
        .o_done    (done),
        .o_sum     (sum),
        .o_cout    (cout),
        .o_cla_a   (cla_a),
        .o_cla_b   (cla_b),
        .o_cla_cin (cla_cin),
        .i_cla_s   (cla_s)
    );

    cla8_seq_ctrl #(.WIDTH(8), .CNT_W(1)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (start8),
        .i_a       (a8),
        .i_b       (b8),
        .i_cin     (cin8),
`ifdef CLA8_SEQ_SUB_EN
        .i_sub     (1'b0),
`endif
        .o_busy    (busy8),
        .o_done    (done8),
        .o_sum     (sum8),
        .o_cout    (cout8),
        .o_cla_a   (cla_a8),
        .o_cla_b   (cla_b8),
        .o_cla_cin (cla_cin8),
        .i_cla_s   (cla_s8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation on the 32-bit instance. With inject set, a second
    // start (a=5,b=5) is pulsed during RUN cycle 2 and must be ignored.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tcin,
                          input logic tsub, input logic [31:0] es, input logic ecout,
                          input logic inject);
        logic [31:0] bq;
        bq    = tsub ? ~tb_v : tb_v;
        a     = ta;
        b     = tb_v;
        cin   = tcin;
        sub   = tsub;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy_run", 64'(busy), 64'(1));
            chk("done_run", 64'(done), 64'(0));
            chk("sum_hold", 64'(sum), 64'(last_sum));
            chk("cla_a_byte", 64'(cla_a), 64'(ta[8*i +: 8]));
            chk("cla_b_byte", 64'(cla_b), 64'(bq[8*i +: 8]));
            cin_seen[i] = cla_cin;
            if (inject && i == 1) begin
                start = 1'b1;
                a     = 32'd5;
                b     = 32'd5;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("done_pulse", 64'(done), 64'(1));
        chk("busy_done", 64'(busy), 64'(0));
        chk("sum", 64'(sum), 64'(es));
        chk("cout", 64'(cout), 64'(ecout));
        chk("cla_a_quiet", 64'(cla_a), 64'(0));
        $display("op a=%08h b=%08h cin=%0d sub=%0d -> sum=%08h cout=%0d", ta, tb_v, tcin, tsub, sum, cout);
        last_sum = es;
        tick();
        chk("done_once", 64'(done), 64'(0));
        chk("sum_after", 64'(sum), 64'(es));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_cla_a", 64'(cla_a), 64'(0));
        chk("rst_cla_b", 64'(cla_b), 64'(0));
        chk("rst_cla_cin", 64'(cla_cin), 64'(0));
        chk("rst_busy8", 64'(busy8), 64'(0));
        chk("rst_sum8", 64'(sum8), 64'(0));
        rst_n = 1'b1;
        tick();

        // 1: byte carry into byte 1
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        chk("t1_cin0", 64'(cin_seen[0]), 64'(0));
        chk("t1_cin1", 64'(cin_seen[1]), 64'(1));
        chk("t1_cin2", 64'(cin_seen[2]), 64'(0));
        chk("t1_cin3", 64'(cin_seen[3]), 64'(0));

        // 2: carry ripples through every byte
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) chk("t2_cin", 64'(cin_seen[i]), 64'(1));

        // 3: only the top byte generates
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) chk("t3_cin", 64'(cin_seen[i]), 64'(0));

        // 4: start during RUN ignored
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("t4_idle_busy", 64'(busy), 64'(0));
            chk("t4_idle_done", 64'(done), 64'(0));
            tick();
        end

        // 5: reset in RUN cycle 2 aborts
        a     = 32'h0000_0001;
        b     = 32'h0000_0002;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t5_busy_pre", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_done", 64'(done), 64'(0));
        chk("t5_sum", 64'(sum), 64'(0));
        chk("t5_cout", 64'(cout), 64'(0));
        chk("t5_cla_a", 64'(cla_a), 64'(0));
        $display("abort: reset during RUN, sum=%08h", sum);
        last_sum = 32'd0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_done", 64'(done), 64'(0));
        end
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0);

`ifdef CLA8_SEQ_SUB_EN
        // 6: subtract
        run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) chk("t6_cin", 64'(cin_seen[i]), 64'(1));
`endif

        // WIDTH=8: single RUN cycle
        a8     = 8'hFF;
        b8     = 8'h01;
        cin8   = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("w8_busy", 64'(busy8), 64'(1));
        chk("w8_cla_a", 64'(cla_a8), 64'(8'hFF));
        chk("w8_done_run", 64'(done8), 64'(0));
        tick();
        chk("w8_done", 64'(done8), 64'(1));
        chk("w8_busy_done", 64'(busy8), 64'(0));
        chk("w8_sum", 64'(sum8), 64'(8'h00));
        chk("w8_cout", 64'(cout8), 64'(1));
        $display("op8 a=%02h b=%02h -> sum=%02h cout=%0d", a8, b8, sum8, cout8);
        tick();
        chk("w8_done_once", 64'(done8), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
